codec_sample_buffer: RTL and testbench
======================================

// Module: codec_sample_buffer
// PURPOSE
//  Decouples the synth/echo sample path from the audio codec frame rate. Samples
//  arriving from echo (out/out_ready) are queued in a small FIFO. One sample is
//  popped per codec frame strobe. The block paces the upstream sine_reader by
//  issuing generate_next requests whenever the FIFO runs low.
// PARAMETERS
//  DEPTH      8   FIFO entries; must be a power of 2, >= 4.
//  LOW_WATER  4   request more samples while occupancy < LOW_WATER (1..DEPTH-1).
// PORTS
//  clk            in   1   system clock; single clock domain.
//  reset          in   1   synchronous, active-high reset.
//  sample_in      in   16  signed sample from echo.
//  in_ready       in   1   one-cycle strobe: sample_in is valid this cycle.
//  new_frame      in   1   one-cycle strobe from codec: consume a sample now.
//  valid_sample   out  16  registered sample presented to codec.
//  generate_next  out  1   one-cycle request pulse to sine_reader.
//  fifo_count     out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
//  underflow      out  1   sticky: new_frame seen while FIFO empty.
//  overflow       out  1   sticky: in_ready seen while FIFO full with no pop.
// BEHAVIOUR
//  Reset (sync): valid_sample=0, generate_next=0, fifo_count=0, underflow=0,
//   overflow=0, pending=0, rd/wr pointers=0. Reset mid-stream discards all
//   contents; the first request may issue on the 1st cycle after reset deasserts.
//  Storage: DEPTH x 16 array. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  Write: on in_ready, if count<DEPTH or a pop occurs the same cycle, store
//   sample_in at wr_ptr and increment wr_ptr. Otherwise drop the sample and set overflow.
//  Read: on new_frame, if count>0, valid_sample <= mem[rd_ptr] at the next edge
//   (1-cycle latency) and rd_ptr increments. If count==0, set underflow and hold
//   valid_sample at its previous value (no repeat of a stale FIFO entry).
//  Simultaneous in_ready+new_frame:
//   count==DEPTH -> pop and push both happen; count unchanged; no overflow.
//   count==0     -> no bypass; underflow set; pushed sample stored; count=1.
//   otherwise    -> count unchanged.
//  Request FSM (one pending request max):
//   IDLE:   if (count_next < LOW_WATER), pulse generate_next for 1 cycle -> WAIT.
//   WAIT:   on in_ready -> IDLE; generate_next stays 0.
//   count_next is the post-update occupancy for this cycle.
//   Upstream may produce the sample many cycles later; no timeout.
//  Sticky flags clear only on reset. The flags do not alter data flow.
//  fifo_count updates on the same edge as the push/pop it reflects.
// TESTING
//  1 Reset: hold reset 2 cycles -> all outputs 0; 1 cycle after release,
//    generate_next pulses once (count 0 < 4).
//  2 Fill: respond to each request with in_ready, samples 16'h0001..16'h0004 ->
//    requests stop once count==4; fifo_count==4; no further pulse without a pop.
//  3 Drain: 4 new_frame strobes 10 cycles apart -> valid_sample 1,2,3,4, each
//    1 cycle after its strobe; a 5th strobe -> underflow=1, valid_sample stays 4.
//  4 Overflow: force 9 in_ready strobes with no new_frame (DEPTH=8) -> 9th
//    sample (16'hBEEF) dropped; overflow=1; fifo_count==8; order preserved on drain.
//  5 Simultaneous: count==8, in_ready(16'h00AA)+new_frame in the same cycle ->
//    count stays 8, overflow stays 0, 16'h00AA read out last. At count==0,
//    both strobes -> underflow=1, count==1.
//  6 Wrap/reset: run 20 push/pop pairs (pointer wrap) and check order; assert
//    reset with count==5 -> count 0, flags 0, valid_sample 0 next cycle.

Source files
------------

// File: rtl/codec_sample_buffer.sv
// Sample FIFO between the echo path and the codec frame strobe; paces the
// upstream sine_reader with single outstanding generate_next requests.
module codec_sample_buffer #(
  parameter int DEPTH     = 8,
  parameter int LOW_WATER = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              sample_in,
  input  logic                     in_ready,
  input  logic                     new_frame,
  output logic [15:0]              valid_sample,
  output logic                     generate_next,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     underflow,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    WAIT
  } req_state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   valid_sample_q, valid_sample_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;
  logic          generate_next_q, generate_next_d;
  req_state_t    state_q, state_d;

  logic          pop;
  logic          push;
  logic          full;
  logic          empty;

  // When full, a same-cycle pop frees the slot the push lands in; the read
  // sees the old contents because the write only commits at the edge.
  always_comb begin
    empty          = (count_q == '0);
    full           = (count_q == CW'(DEPTH));
    pop            = new_frame && !empty;
    push           = in_ready && (!full || pop);
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    valid_sample_d = valid_sample_q;
    underflow_d    = underflow_q;
    overflow_d     = overflow_q;
    if (pop) begin
      valid_sample_d = mem_q[rd_ptr_q];
      rd_ptr_d       = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = sample_in;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (new_frame && empty) begin
      underflow_d = 1'b1;
    end
    if (in_ready && !push) begin
      overflow_d = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Request decision looks at the post-update occupancy so a pop this cycle
  // can trigger a refill request immediately.
  always_comb begin
    state_d         = state_q;
    generate_next_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_d < CW'(LOW_WATER)) begin
          generate_next_d = 1'b1;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (in_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      valid_sample_q  <= '0;
      underflow_q     <= 1'b0;
      overflow_q      <= 1'b0;
      generate_next_q <= 1'b0;
      state_q         <= IDLE;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      valid_sample_q  <= valid_sample_d;
      underflow_q     <= underflow_d;
      overflow_q      <= overflow_d;
      generate_next_q <= generate_next_d;
      state_q         <= state_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_sample  = valid_sample_q;
  assign generate_next = generate_next_q;
  assign fifo_count    = count_q;
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_codec_sample_buffer.sv
// Self-checking bench for codec_sample_buffer: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_codec_sample_buffer;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        in_ready;
  logic        new_frame;
  logic [15:0] valid_sample;
  logic        generate_next;
  logic [3:0]  fifo_count;
  logic        underflow;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_vs;
  bit          m_gen;
  bit          m_pend;
  bit          m_uf;
  bit          m_of;

  always #5 clk = ~clk;

  codec_sample_buffer #(.DEPTH(DEPTH), .LOW_WATER(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .in_ready     (in_ready),
    .new_frame    (new_frame),
    .valid_sample (valid_sample),
    .generate_next(generate_next),
    .fifo_count   (fifo_count),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a plain queue; pop happens before push so a full FIFO with a
  // simultaneous frame strobe accepts the new sample, an empty one does not bypass.
  task automatic modelStep(input bit rst, input bit ir, input logic [15:0] s, input bit nf);
    if (rst) begin
      m_q.delete();
      m_vs   = '0;
      m_gen  = 0;
      m_pend = 0;
      m_uf   = 0;
      m_of   = 0;
    end else begin
      m_gen = 0;
      if (nf) begin
        if (m_q.size() > 0) m_vs = m_q.pop_front();
        else m_uf = 1;
      end
      if (ir) begin
        if (m_q.size() < DEPTH) m_q.push_back(s);
        else m_of = 1;
      end
      if (!m_pend) begin
        if (m_q.size() < LW) begin
          m_gen  = 1;
          m_pend = 1;
        end
      end else if (ir) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ir, input logic [15:0] s, input bit nf);
    @(negedge clk);
    reset     = rst;
    in_ready  = ir;
    sample_in = s;
    new_frame = nf;
    @(posedge clk);
    modelStep(rst, ir, s, nf);
    #1;
    checkOutput("valid_sample", 32'(valid_sample), 32'(m_vs));
    checkOutput("generate_next", 32'(generate_next), 32'(m_gen));
    checkOutput("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    checkOutput("underflow", 32'(underflow), 32'(m_uf));
    checkOutput("overflow", 32'(overflow), 32'(m_of));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vs"}, 32'(valid_sample), 32'h0);
    checkOutput({tag, "_gen"}, 32'(generate_next), 32'h0);
    checkOutput({tag, "_cnt"}, 32'(fifo_count), 32'h0);
    checkOutput({tag, "_uf"}, 32'(underflow), 32'h0);
    checkOutput({tag, "_of"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [15:0] s;
    bit ir, nf, rst;
    reset = 1'b1; in_ready = 1'b0; new_frame = 1'b0; sample_in = '0;

    // Reset for two cycles, then the first request one cycle after release
    applyStimulus(1, 0, 16'h0, 0);
    applyStimulus(1, 0, 16'h0, 0);
    checkAllZero("reset");
    applyStimulus(0, 0, 16'h0, 0);
    checkOutput("first_req", 32'(generate_next), 32'h1);

    // Fill by answering each request
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 1, 16'(k), 0);
      if (k < 4) begin
        applyStimulus(0, 0, 16'h0, 0);
        checkOutput("fill_req", 32'(generate_next), 32'h1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 16'h0, 0);
      checkOutput("fill_noreq", 32'(generate_next), 32'h0);
    end
    checkOutput("fill_count", 32'(fifo_count), 32'h4);

    // Drain with spaced frame strobes, then one strobe too many
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 16'h0, 1);
      checkOutput("drain_vs", 32'(valid_sample), 32'(k));
      for (int i = 0; i < 9; i++) applyStimulus(0, 0, 16'h0, 0);
    end
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("drain_uf", 32'(underflow), 32'h1);
    checkOutput("drain_hold", 32'(valid_sample), 32'h4);

    // Overflow: ninth push dropped, order preserved
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 16'h0010 + 16'(i), 0);
    checkOutput("ovf_before", 32'(overflow), 32'h0);
    applyStimulus(0, 1, 16'hBEEF, 0);
    checkOutput("ovf_flag", 32'(overflow), 32'h1);
    checkOutput("ovf_count", 32'(fifo_count), 32'h8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 16'h0, 1);
      checkOutput("ovf_order", 32'(valid_sample), 32'h0010 + 32'(i));
    end

    // Simultaneous push+pop when full and when empty
    applyStimulus(1, 0, 16'h0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 16'h0020 + 16'(i), 0);
    applyStimulus(0, 1, 16'h00AA, 1);
    checkOutput("sim_full_cnt", 32'(fifo_count), 32'h8);
    checkOutput("sim_full_of", 32'(overflow), 32'h0);
    checkOutput("sim_full_vs", 32'(valid_sample), 32'h0020);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 16'h0, 1);
    checkOutput("sim_last_aa", 32'(valid_sample), 32'h00AA);
    applyStimulus(0, 1, 16'h0055, 1);
    checkOutput("sim_empty_uf", 32'(underflow), 32'h1);
    checkOutput("sim_empty_cnt", 32'(fifo_count), 32'h1);
    checkOutput("sim_empty_vs", 32'(valid_sample), 32'h00AA);

    // Pointer wrap with push/pop pairs, then reset mid-stream at count 5
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 16'($urandom), 0);
      applyStimulus(0, 0, 16'h0, 1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'($urandom), 0);
    checkOutput("wrap_cnt5", 32'(fifo_count), 32'h5);
    applyStimulus(1, 0, 16'h0, 0);
    checkAllZero("midreset");

    // Random traffic; upstream answers requests after a random delay
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ir  = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      nf  = ($urandom_range(0, 3) == 0);
      s   = 16'($urandom);
      applyStimulus(rst, ir, s, nf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
